// File: rtl/led_pkg.sv
// Shared types for the LED pulse array: mode encodings and the per-channel config record.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_WIN     = 2'd2,
      LED_WIN_INV = 2'd3
   } led_mode_e;

   // Window bounds are carried at a fixed maximum width; channels compare
   // against a zero-extended counter, so unused upper bits stay zero.
   localparam int unsigned CFG_CNT_W = 32;

   typedef struct packed {
      led_mode_e              mode;
      logic [CFG_CNT_W-1:0]   win_start;
      logic [CFG_CNT_W-1:0]   win_end;
   } led_cfg_t;

   localparam led_cfg_t LED_CFG_RESET = '{mode: LED_OFF, win_start: '0, win_end: '0};

endpackage

// File: rtl/led_channel.sv
// One LED channel: double-buffered config (shadow -> active at wrap) and a registered LED bit.
module led_channel
   import led_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic             wrap,
   input  logic             we,
   input  led_cfg_t         cfg,
   output logic             led,
   output logic             pending
);

   led_cfg_t             shadow_q, shadow_d;
   led_cfg_t             active_q, active_d;
   logic                 pending_q, pending_d;
   logic                 led_q, led_d;
   logic                 in_win;
   logic [CFG_CNT_W-1:0] cnt_ext;

   assign cnt_ext = CFG_CNT_W'(cnt);

   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      led_d     = 1'b0;
      // Promote before accepting a new write so a write in the wrap cycle waits a period.
      if (wrap && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (we) begin
         shadow_d  = cfg;
         pending_d = 1'b1;
      end
      in_win = (cnt_ext >= active_q.win_start) && (cnt_ext <= active_q.win_end);
      unique case (active_q.mode)
         LED_OFF:     led_d = 1'b0;
         LED_ON:      led_d = 1'b1;
         LED_WIN:     led_d = in_win;
         LED_WIN_INV: led_d = !in_win;
         default:     led_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q  <= LED_CFG_RESET;
         active_q  <= LED_CFG_RESET;
         pending_q <= 1'b0;
         led_q     <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         led_q     <= led_d;
      end
   end

   assign led     = led_q;
   assign pending = pending_q;

endmodule

// File: rtl/led_pulse_array.sv
// N_CH LED outputs driven from one shared period counter, each with its own on-window and mode.
module led_pulse_array
   import led_pkg::*;
#(
   parameter  int unsigned PERIOD_CYC = 5_000_000,
   parameter  int unsigned N_CH       = 4,
   parameter  int unsigned CNT_W      = $clog2(PERIOD_CYC),
   localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_start,
   input  logic [CNT_W-1:0] cfg_end,
   output logic [N_CH-1:0]  cfg_pending,
   output logic             period_tick,
   output logic [N_CH-1:0]  LED_Out
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q;
   logic             wrap;
   logic [N_CH-1:0]  ch_we;
   led_cfg_t         cfg_in;

   assign wrap  = (cnt_q == CNT_W'(PERIOD_CYC - 1));
   assign cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= wrap;
      end
   end

   assign period_tick = tick_q;

   assign cfg_in = '{
      mode:      led_mode_e'(cfg_mode),
      win_start: CFG_CNT_W'(cfg_start),
      win_end:   CFG_CNT_W'(cfg_end)
   };

   // Indices >= N_CH match no channel, so such writes are dropped.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

      led_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk     (CLK),
         .rst     (RST),
         .cnt     (cnt_q),
         .wrap    (wrap),
         .we      (ch_we[i]),
         .cfg     (cfg_in),
         .led     (LED_Out[i]),
         .pending (cfg_pending[i])
      );
   end

endmodule

// File: tb/tb_led_pulse_array.sv
// Directed bench for led_pulse_array with PERIOD_CYC=10: a 4-channel DUT plus a 3-channel one.
module tb_led_pulse_array;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       cfg_we = 1'b0;
   logic       cfg_we3 = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [1:0] cfg_mode = '0;
   logic [3:0] cfg_start = '0;
   logic [3:0] cfg_end = '0;
   logic [3:0] cfg_pending, led_out;
   logic       period_tick;
   logic [2:0] cfg_pending3, led_out3;
   logic       period_tick3;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   led_pulse_array #(
      .PERIOD_CYC (10),
      .N_CH       (4)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .cfg_start   (cfg_start),
      .cfg_end     (cfg_end),
      .cfg_pending (cfg_pending),
      .period_tick (period_tick),
      .LED_Out     (led_out)
   );

   led_pulse_array #(
      .PERIOD_CYC (10),
      .N_CH       (3)
   ) dut3 (
      .CLK         (CLK),
      .RST         (RST),
      .cfg_we      (cfg_we3),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .cfg_start   (cfg_start),
      .cfg_end     (cfg_end),
      .cfg_pending (cfg_pending3),
      .period_tick (period_tick3),
      .LED_Out     (led_out3)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
      cyc += n;
   endtask

   task automatic wr(input logic sel3, input logic [1:0] ch, input logic [1:0] mode,
                     input logic [3:0] s, input logic [3:0] e);
      cfg_ch    = ch;
      cfg_mode  = mode;
      cfg_start = s;
      cfg_end   = e;
      if (sel3) cfg_we3 = 1'b1;
      else      cfg_we  = 1'b1;
      step(1);
      cfg_we  = 1'b0;
      cfg_we3 = 1'b0;
   endtask

   initial begin
      logic w0;
      // Reset and idle: ticks only after each wrap, LEDs dark
      step(2);
      RST = 1'b0;
      cyc = 0;
      check("rst_led", 32'(led_out), 32'h0);
      check("rst_pend", 32'(cfg_pending), 32'h0);
      check("rst_tick", 32'(period_tick), 32'h0);
      for (int i = 0; i < 30; i++) begin
         step(1);
         check("idle_tick", 32'(period_tick), 32'((cyc == 10) || (cyc == 20) || (cyc == 30)));
         check("idle_led", 32'(led_out), 32'h0);
      end

      // ch0 WINDOW 2..4 written at counter 3
      step(3);
      wr(1'b0, 2'd0, 2'd2, 4'd2, 4'd4);
      check("win_pend", 32'(cfg_pending), 32'h1);
      step(5);
      check("win_pend_wrap", 32'(cfg_pending), 32'h1);
      for (int i = 0; i < 11; i++) begin
         step(1);
         if (cyc == 40) begin
            check("win_pend_clr", 32'(cfg_pending), 32'h0);
            check("win_tick", 32'(period_tick), 32'h1);
         end
         check("win_led0", 32'(led_out[0]),
               32'(cyc != 40 && (cyc % 10) >= 3 && (cyc % 10) <= 5));
      end

      // ch1 WINDOW_INV with start > end; ch2 ON then OFF in one period
      wr(1'b0, 2'd1, 2'd3, 4'd7, 4'd3);
      wr(1'b0, 2'd2, 2'd1, 4'd0, 4'd0);
      wr(1'b0, 2'd2, 2'd0, 4'd0, 4'd0);
      check("inv_pend", 32'(cfg_pending), 32'h6);
      step(7);
      check("inv_pend_clr", 32'(cfg_pending), 32'h0);
      check("inv_led_old", 32'(led_out), 32'h0);
      for (int i = 0; i < 10; i++) begin
         step(1);
         w0 = (cyc % 10) >= 3 && (cyc % 10) <= 5;
         check("inv_leds", 32'(led_out), 32'({3'b001, w0}));
      end

      // ch3 ON written exactly in the wrap cycle
      step(9);
      wr(1'b0, 2'd3, 2'd1, 4'd0, 4'd0);
      check("wrapwr_pend", 32'(cfg_pending), 32'h8);
      for (int i = 0; i < 11; i++) begin
         step(1);
         check("wrapwr_led3", 32'(led_out[3]), 32'(cyc >= 91));
         check("wrapwr_pend", 32'(cfg_pending), (cyc <= 89) ? 32'h8 : 32'h0);
      end

      // Out-of-range index on the 3-channel instance, then a valid write
      wr(1'b1, 2'd3, 2'd1, 4'd0, 4'd9);
      check("oor_pend", 32'(cfg_pending3), 32'h0);
      wr(1'b1, 2'd2, 2'd1, 4'd0, 4'd0);
      check("oor_valid_pend", 32'(cfg_pending3), 32'h4);
      step(8);
      check("oor_led", 32'(led_out3), 32'h4);

      // Reset mid-period with ch0 active and ch1 pending (ON)
      wr(1'b0, 2'd1, 2'd1, 4'd0, 4'd0);
      check("pre_rst_pend", 32'(cfg_pending), 32'h2);
      step(4);
      check("pre_rst_led", 32'(led_out), 32'ha);
      #2 RST = 1'b1;
      #2;
      check("async_led", 32'(led_out), 32'h0);
      check("async_pend", 32'(cfg_pending), 32'h0);
      check("async_led3", 32'(led_out3), 32'h0);
      check("async_pend3", 32'(cfg_pending3), 32'h0);
      @(posedge CLK);
      #1 RST = 1'b0;
      cyc = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         check("post_rst_tick", 32'(period_tick), 32'(cyc == 10));
         check("post_rst_led", 32'(led_out), 32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_pulse_array.md
# led_pulse_array

Multi-channel, parametrised successor of the single-LED timed pulse generator. One shared period counter drives N_CH independent LED outputs. Each output has a runtime-configurable on-window and mode, written through a simple config port. Config changes are double-buffered and take effect only at a period boundary, so no LED ever shows a partial or glitched period. Sits between the board-level LED pins and any control logic, such as a UART command decoder or a key scanner.

## Interface
- PERIOD_CYC, 5_000_000: period length in CLK cycles (100 ms at 50 MHz); must be ≥ 2.
- N_CH, 4: number of LED channels; must be ≥ 1.
- CNT_W, $clog2(PERIOD_CYC): counter and compare width (23 for the default).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=WINDOW, 3=WINDOW_INV.
- cfg_start  in  CNT_W  first counter value of the on-window (inclusive).
- cfg_end  in  CNT_W  last counter value of the on-window (inclusive).
- cfg_pending  out  N_CH  per channel: a written config is waiting for the boundary.
- period_tick  out  1  one-cycle pulse at each period start.
- LED_Out  out  N_CH  registered LED drive, active-high.

## Operation
- Counter:
  - Counts 0 … PERIOD_CYC-1, then wraps to 0.
  - The wrap cycle is the cycle in which the counter equals PERIOD_CYC-1.
  - The period is exactly PERIOD_CYC cycles.
- Per-channel state:
  - Shadow config {mode, start, end}.
  - Active config {mode, start, end}.
  - pending bit.
- On a write (cfg_we=1, cfg_ch < N_CH):
  - shadow[cfg_ch] is loaded with the new mode, start and end.
  - pending[cfg_ch] is set to 1.
- A write with cfg_ch ≥ N_CH is ignored; no state changes.
- In the wrap cycle, for every channel with pending=1:
  - active is loaded from shadow.
  - pending is cleared.
- A write in the wrap cycle:
  - The new value goes to shadow and pending stays 1.
  - active takes the shadow contents from before this write.
  - The new value is applied at the next wrap.
- Back-to-back writes to the same channel within one period: the last write wins.
- in_win = (counter ≥ start) && (counter ≤ end), unsigned compare at CNT_W bits.
- LED value per active mode:
  - OFF: 0.
  - ON: 1.
  - WINDOW: in_win.
  - WINDOW_INV: !in_win.
- Boundary cases:
  - start > end: the window is empty, so WINDOW is always 0 and WINDOW_INV is always 1.
  - end ≥ PERIOD_CYC: the window extends to the end of the period.
  - start = end: the window is one cycle wide.

## Timing
- Reset values (asynchronous, while RST=1):
  - counter = 0.
  - LED_Out = 0.
  - period_tick = 0.
  - cfg_pending = 0.
  - All shadow and active configs = OFF, start 0, end 0.
- LED_Out[i] at cycle k+1 reflects the counter and active[i] at cycle k (one-cycle latency).
- cfg_pending[i] rises in the cycle after the write and falls in the cycle after the wrap that applies it.
- A new config affects LED_Out from the first cycle of the new period + 1. That is the LED value computed for counter=0.
- period_tick:
  - High for one cycle, in the cycle when the counter reads 0 after a wrap.
  - Not asserted in the first period after reset release.
- If RST asserts mid-period, everything returns to reset values immediately, and pending writes are lost.
- After RST deasserts, counting starts at 0 on the first CLK edge.

## Structure
- Package led_pkg holds:
  - The mode encodings LED_OFF, LED_ON, LED_WIN, LED_WIN_INV.
  - A struct led_cfg_t {mode, start, end} parametrised by CNT_W. Use localparam widths where a parametrised struct is unsupported.
- Sub-module led_channel, instantiated N_CH times via generate, holds per-channel logic:
  - Inputs: counter, wrap, write-enable, cfg.
  - Outputs: LED bit, pending.
- The top level holds:
  - The counter.
  - The wrap and period_tick logic.
  - The cfg_ch decode.

## Test plan
Use PERIOD_CYC=10, N_CH=4.
1. Reset, then no writes for 30 cycles → LED_Out=0000, period_tick pulses at cycles 10 and 20 counter-relative, and never before the first wrap.
2. Write ch0 WINDOW start=2 end=4 mid-period → pending[0]=1 until the wrap. In the next period LED_Out[0] is high for exactly 3 cycles, lagging counter values 2–4 by one cycle.
3. Write ch1 WINDOW_INV start=7 end=3 → LED_Out[1] is constantly 1 from the next period. Write ch2 ON, then ch2 OFF in the same period → ch2 stays 0.
4. Write ch3 ON exactly in the wrap cycle, with ch3 pending=0 beforehand → ch3 stays OFF for one full period and turns on after the following wrap.
5. Write cfg_ch=5 (N_CH=8 width case), or an out-of-range index for N_CH=3 → no change on any output or pending bit.
6. Assert RST at counter=6 with ch0 active and ch1 pending → all outputs and pending bits clear asynchronously. After release, ch0 is OFF and the counter restarts at 0.
